// File: rtl/bram2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram2_port_arbiter
//  Purpose  : Shares one port of a dual-ported BRAM between NUM_REQ
//             requesters. A round-robin arbiter grants at most one read or
//             write per cycle. The granted request drives the BRAM port, and
//             each read's data is routed back to the requester that issued it.
//  Ports    : clk, rst_n          - clock (shared with BRAM), async active-low reset
//             req_valid/req_we    - per-requester valid and write(1)/read(0)
//             req_addr/req_data   - packed per-requester address / write data
//             req_ready           - one-hot grant (combinational)
//             rsp_valid/rsp_data  - one-hot read strobe and shared read data
//             bram_en/we/addr/di  - BRAM port drive (combinational)
//             bram_do             - BRAM port read data
//  Revision : 1.0  initial release
// ============================================================================
module bram2_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int PIPELINED  = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic                           bram_en,
   output logic                           bram_we,
   output logic [ADDR_WIDTH-1:0]          bram_addr,
   output logic [DATA_WIDTH-1:0]          bram_di,
   input  logic [DATA_WIDTH-1:0]          bram_do
);

   localparam int              IDX_W     = $clog2(NUM_REQ);
   localparam int              LAT       = PIPELINED + 1;
   localparam logic [IDX_W:0]  NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]            prio_q, prio_d;
   logic                        grant_any;
   logic [IDX_W-1:0]            grant_idx;
   logic [IDX_W:0]              cand;

   // Read-tag pipeline: one stage per cycle of BRAM read latency.
   logic [LAT-1:0]              tag_vld_q, tag_vld_d;
   logic [LAT-1:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;

   // Round-robin search starting at prio_q. The candidate is computed one bit
   // wider than an index so the modulo wrap works for any NUM_REQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, prio_q} + (IDX_W+1)'(k);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (!grant_any && req_valid[cand[IDX_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

   // BRAM drive: mux the granted requester's slice, all zero when idle.
   always_comb begin
      req_ready = '0;
      bram_en   = grant_any;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_di   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_any && (grant_idx == IDX_W'(i))) begin
            req_ready[i] = 1'b1;
            bram_we      = req_we[i];
            bram_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            bram_di      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next priority: one past the winner, wrapping at NUM_REQ-1.
   always_comb begin
      prio_d = prio_q;
      if (grant_any) begin
         prio_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
   end

   // Stage 0 captures read grants; later stages shift unconditionally, so
   // responses leave in grant order with a fixed LAT-cycle lag.
   always_comb begin
      tag_vld_d    = '0;
      tag_idx_d    = '0;
      tag_vld_d[0] = bram_en & ~bram_we;
      tag_idx_d[0] = grant_idx;
      for (int s = 1; s < LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_idx_d[s] = tag_idx_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q    <= '0;
         tag_vld_q <= '0;
         tag_idx_q <= '0;
      end else begin
         prio_q    <= prio_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
      end
   end

   // Response decode from the final tag stage; data is gated so it reads
   // zero whenever no response is being delivered.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (tag_vld_q[LAT-1]) begin
         rsp_valid = NUM_REQ'(1) << tag_idx_q[LAT-1];
         rsp_data  = bram_do;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bram2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram2_port_arbiter
//  Purpose  : Drives two arbiter instances (non-pipelined and pipelined BRAM)
//             from a shared stimulus, each attached to its own BRAM model, and
//             compares every output against a transaction-level reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bram2_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;

   logic [N-1:0]  ready0, ready1, rspv0, rspv1;
   logic [DW-1:0] rspd0, rspd1, di0, di1, do0, do1;
   logic          en0, en1, we0, we1;
   logic [AW-1:0] addr0, addr1;

   bram2_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data), .req_ready(ready0),
      .rsp_valid(rspv0), .rsp_data(rspd0), .bram_en(en0), .bram_we(we0),
      .bram_addr(addr0), .bram_di(di0), .bram_do(do0));

   bram2_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data), .req_ready(ready1),
      .rsp_valid(rspv1), .rsp_data(rspd1), .bram_en(en1), .bram_we(we1),
      .bram_addr(addr1), .bram_di(di1), .bram_do(do1));

   // BRAM models: 1-cycle read for instance 0, 2-cycle (output register) for 1.
   logic [DW-1:0] mem0 [1024];
   logic [DW-1:0] mem1 [1024];
   logic [DW-1:0] do_s0, do_s1, do_p1;
   always @(posedge clk) begin
      if (en0) begin
         if (we0) mem0[addr0] <= di0;
         else     do_s0       <= mem0[addr0];
      end
      if (en1) begin
         if (we1) mem1[addr1] <= di1;
         else     do_s1       <= mem1[addr1];
      end
      do_p1 <= do_s1;
   end
   assign do0 = do_s0;
   assign do1 = do_p1;

   // Reference model state
   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          q0[$];
   rsp_t          q1[$];
   logic [DW-1:0] ref_mem [1024];
   int            prio_m;
   int            cyc;
   int            vecs;
   int            miscompares;

   // Pending request per requester, held until granted.
   logic          pv    [N];
   logic          pwe   [N];
   logic [AW-1:0] paddr [N];
   logic [DW-1:0] pdata [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         pv[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pv[i] = 1'b1; pwe[i] = we; paddr[i] = a; pdata[i] = d;
   endtask

   // One clock cycle: drive pending requests, check every output against the
   // model, then advance the model by the grant it predicted.
   task automatic step();
      int            g;
      int            j;
      logic [N-1:0]  ev;
      logic [DW-1:0] ed;
      logic [N-1:0]  er;
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = pv[i];
         req_we[i]             = pwe[i];
         req_addr[i*AW +: AW]  = paddr[i];
         req_data[i*DW +: DW]  = pdata[i];
      end
      #2;
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         prio_m = 0;
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
         j = (prio_m + k) % N;
         if (g < 0 && pv[j]) g = j;
      end
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready0", ready0, er);
      chk("req_ready1", ready1, er);
      chk("bram_en",    en0,   (g >= 0));
      chk("bram_we",    we0,   (g >= 0) ? pwe[g]   : 1'b0);
      chk("bram_addr",  addr0, (g >= 0) ? paddr[g] : '0);
      chk("bram_di",    di0,   (g >= 0) ? pdata[g] : '0);
      chk("bram_en1",   {en1, we1, addr1, di1}, {en0, we0, addr0, di0});

      ev = '0; ed = '0;
      if (q0.size() > 0 && q0[0].due == cyc) begin
         ev = N'(1) << q0[0].idx; ed = q0[0].data; void'(q0.pop_front());
      end
      chk("rsp_valid_p0", rspv0, ev);
      chk("rsp_data_p0",  rspd0, ed);
      ev = '0; ed = '0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
         ev = N'(1) << q1[0].idx; ed = q1[0].data; void'(q1.pop_front());
      end
      chk("rsp_valid_p1", rspv1, ev);
      chk("rsp_data_p1",  rspd1, ed);

      if (rst_n && g >= 0) begin
         prio_m = (g + 1) % N;
         if (pwe[g]) begin
            ref_mem[paddr[g]] = pdata[g];
         end else begin
            q0.push_back('{cyc + 1, g, ref_mem[paddr[g]]});
            q1.push_back('{cyc + 2, g, ref_mem[paddr[g]]});
         end
         pv[g] = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step();
   endtask

   initial begin
      vecs = 0; miscompares = 0; cyc = 0; prio_m = 0;
      req_valid = '0; req_we = '0; req_addr = '0; req_data = '0;
      clear_reqs();
      for (int i = 0; i < 1024; i++) begin
         mem0[i]    = 32'hA5000000 + i;
         mem1[i]    = 32'hA5000000 + i;
         ref_mem[i] = 32'hA5000000 + i;
      end
      @(negedge clk);

      // Reset state
      step();
      rst_n = 1'b1;
      idle(1);

      // 1. All four read, held for 8 cycles: 0,1,2,3,0,1,2,3
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!pv[i]) set_req(i, 1'b0, AW'(16 + i), '0);
         step();
      end
      clear_reqs();
      idle(3);

      // 2. Write then read-after-write on the next cycle
      set_req(2, 1'b1, 10'd5, 32'hDEADBEEF);
      step();
      set_req(0, 1'b0, 10'd5, '0);
      step();
      idle(3);

      // 3. Back-to-back reads from requester 3
      for (int a = 1; a <= 3; a++) begin
         set_req(3, 1'b0, AW'(a), '0);
         step();
      end
      idle(3);

      // 4. Wrap-around: grant 2 (prio->3), then 0011 grants 0 then 1
      set_req(2, 1'b0, 10'd9, '0);
      step();
      set_req(0, 1'b0, 10'd10, '0);
      set_req(1, 1'b0, 10'd11, '0);
      step();
      step();
      idle(3);

      // Randomized traffic with read-after-write over a small address window
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
               set_req(i, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)), $urandom);
            end
         end
         step();
      end
      clear_reqs();
      idle(3);

      // 5. Reset pulsed while a read is in flight
      set_req(1, 1'b0, 10'd7, '0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      idle(2);
      set_req(2, 1'b0, 10'd3, '0);
      set_req(3, 1'b0, 10'd4, '0);
      step();
      step();
      idle(3);

      // 6. Only writes and idle cycles
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pv[i] && ($urandom_range(0, 3) == 0)) begin
               set_req(i, 1'b1, AW'($urandom_range(0, 15)), $urandom);
            end
         end
         step();
      end
      clear_reqs();
      idle(3);

      // Read back the written window
      for (int a = 0; a < 16; a++) begin
         set_req(a % N, 1'b0, AW'(a), '0);
         step();
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
